// File: rtl/imem_pkg.sv
// Types and constants shared by the instruction memory, its boot loader and the CPU top.
package imem_pkg;
  localparam int         IMEM_ADDR_W    = 10;
  localparam logic [7:0] IMEM_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;
endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input, instruction-memory write port and loader status, bundled.
interface imem_boot_loader_if #(
  parameter int ADDR_W = imem_pkg::IMEM_ADDR_W
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err, words_loaded
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data, cpu_hold, load_done, load_err, words_loaded
  );
endinterface

// File: rtl/imem_word_packer.sv
// Packs little-endian bytes into 32-bit words; word/word_vld appear the cycle after the 4th byte.
// No back-pressure: one byte per cycle, o_last flags the completing byte combinationally.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic        o_last,
  output logic [31:0] o_word,
  output logic        o_word_vld
);
  logic [1:0]  r_idx;
  logic [31:0] r_sh;
  logic [31:0] r_word;
  logic        r_vld;

  assign o_last     = i_push & ~i_clr & (r_idx == 2'd3);
  assign o_word     = r_word;
  assign o_word_vld = r_vld;

  // Shift in at the top so the first byte ends up in [7:0] after four pushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= 2'd0;
      r_sh   <= '0;
      r_word <= '0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= o_last;
      if (i_clr) begin
        r_idx <= 2'd0;
        r_sh  <= '0;
      end else if (i_push) begin
        r_idx <= r_idx + 2'd1;
        r_sh  <= {i_byte, r_sh[31:8]};
        if (o_last) r_word <= {i_byte, r_sh[31:8]};
      end
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// Frame parser (SYNC, LEN_LO, LEN_HI, data[, csum if IMEM_LOADER_CHECKSUM_EN]) writing words from addr 0;
// wr_en one cycle after each 4th data byte, rx_ready held high until DONE/ERR (no back-pressure).
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int         ADDR_W    = IMEM_ADDR_W,
  parameter logic [7:0] SYNC_BYTE = IMEM_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_boot_loader_if.slave bus
);
  localparam logic [16:0]   DEPTH = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  loader_state_t     r_state;
  logic              r_rx_rdy, r_hold, r_done, r_err;
  logic [ADDR_W:0]   r_words, r_len;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_len_lo;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_acc, w_push, w_clr, w_last, w_word_vld;
  logic [31:0]       w_word;
  logic [15:0]       w_len;
  logic [ADDR_W:0]   w_words_nxt;

  assign w_acc       = bus.rx_valid & r_rx_rdy;
  assign w_push      = w_acc & (r_state == DATA);
  assign w_clr       = bus.start & ((r_state == DONE) | (r_state == ERR));
  assign w_len       = {bus.rx_data, r_len_lo};
  assign w_words_nxt = r_words + ONE;

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_push     (w_push),
    .i_byte     (bus.rx_data),
    .o_last     (w_last),
    .o_word     (w_word),
    .o_word_vld (w_word_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rx_rdy  <= 1'b1;
      r_hold    <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_words   <= '0;
      r_len     <= '0;
      r_wr_addr <= '0;
      r_len_lo  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_acc && bus.rx_data == SYNC_BYTE) begin
          r_state <= LEN0;
          r_words <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_csum  <= '0;
`endif
        end
        LEN0: if (w_acc) begin
          r_len_lo <= bus.rx_data;
          r_state  <= LEN1;
        end
        LEN1: if (w_acc) begin
          // Oversized images are rejected before any write so wr_addr can never wrap.
          if ({1'b0, w_len} > DEPTH) begin
            r_state  <= ERR;
            r_err    <= 1'b1;
            r_rx_rdy <= 1'b0;
          end else if (w_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state  <= CSUM;
`else
            r_state  <= DONE;
            r_done   <= 1'b1;
            r_hold   <= 1'b0;
            r_rx_rdy <= 1'b0;
`endif
          end else begin
            r_len   <= w_len[ADDR_W:0];
            r_state <= DATA;
          end
        end
        DATA: if (w_acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_csum <= r_csum ^ bus.rx_data;
`endif
          if (w_last) begin
            r_wr_addr <= r_words[ADDR_W-1:0];
            r_words   <= w_words_nxt;
            if (w_words_nxt == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state  <= CSUM;
`else
              r_state  <= DONE;
              r_done   <= 1'b1;
              r_hold   <= 1'b0;
              r_rx_rdy <= 1'b0;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: if (w_acc) begin
          r_rx_rdy <= 1'b0;
          if (bus.rx_data == r_csum) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_hold  <= 1'b0;
          end else begin
            r_state <= ERR;
            r_err   <= 1'b1;
          end
        end
`endif
        DONE, ERR: if (bus.start) begin
          r_state   <= IDLE;
          r_done    <= 1'b0;
          r_err     <= 1'b0;
          r_hold    <= 1'b1;
          r_rx_rdy  <= 1'b1;
          r_words   <= '0;
          r_wr_addr <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rx_ready     = r_rx_rdy;
  assign bus.wr_en        = w_word_vld;
  assign bus.wr_addr      = r_wr_addr;
  assign bus.wr_data      = w_word;
  assign bus.cpu_hold     = r_hold;
  assign bus.load_done    = r_done;
  assign bus.load_err     = r_err;
  assign bus.words_loaded = r_words;
endmodule
